// File: rtl/sha_clock_divider_if.sv
// Divided-clock output bundle for the sample-and-hold clock divider.
// The master drives outClk; downstream sample-and-hold logic takes the slave view.
interface sha_clock_divider_if;
   logic outClk;

   modport master (
      output outClk
   );

   modport slave (
      input outClk
   );
endinterface

// File: rtl/sha_clock_divider.sv
// Divides inClk by DIV with a wrapping counter; outClk is high for HIGH_CYCLES
// of every DIV input cycles and always comes straight from a flop.
module sha_clock_divider #(
   parameter int unsigned DIV         = 100,
   parameter int unsigned HIGH_CYCLES = DIV / 2
) (
   input  logic                   inClk,
   input  logic                   reset,
   sha_clock_divider_if.master    div_if
);

   // A one-cycle period would still need a 1-bit counter to stay well formed.
   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(DIV - 1);
   localparam logic [CntW-1:0] HighThr = CntW'(HIGH_CYCLES);

   if (DIV < 2) begin : gen_bad_div
      $error("sha_clock_divider: DIV must be at least 2");
   end

   if (HIGH_CYCLES < 1) begin : gen_bad_high_low
      $error("sha_clock_divider: HIGH_CYCLES must be at least 1");
   end

   if (HIGH_CYCLES >= DIV) begin : gen_bad_high_big
      $error("sha_clock_divider: HIGH_CYCLES must be below DIV");
   end

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;
   logic            out_q;
   logic            out_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
      end
      // Decided from the count the edge sees, then registered: no decode glitches.
      out_d = (cnt_q < HighThr);
   end

   always_ff @(posedge inClk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign div_if.outClk = out_q;

endmodule

// File: tb/tb_sha_clock_divider.sv
// Bench for sha_clock_divider: four parameterisations share one clock and reset,
// checked every cycle against an edge-count model plus literal waveform pins.
module tb_sha_clock_divider;

   logic in_clk;
   logic reset;
   logic model_on;
   int   checks;
   int   errors;
   int   n_edges;

   sha_clock_divider_if if_def ();
   sha_clock_divider_if if_d5 ();
   sha_clock_divider_if if_d2 ();
   sha_clock_divider_if if_d7 ();

   sha_clock_divider u_dut_def (
      .inClk  (in_clk),
      .reset  (reset),
      .div_if (if_def)
   );

   sha_clock_divider #(.DIV(5), .HIGH_CYCLES(3)) u_dut5 (
      .inClk  (in_clk),
      .reset  (reset),
      .div_if (if_d5)
   );

   sha_clock_divider #(.DIV(2), .HIGH_CYCLES(1)) u_dut2 (
      .inClk  (in_clk),
      .reset  (reset),
      .div_if (if_d2)
   );

   sha_clock_divider #(.DIV(7)) u_dut7 (
      .inClk  (in_clk),
      .reset  (reset),
      .div_if (if_d7)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   // Rising inClk edges seen since the last reset release.
   always @(posedge in_clk or posedge reset) begin
      if (reset) n_edges <= 0;
      else       n_edges <= n_edges + 1;
   end

   // Edge n (1-based) after release is high when it falls in the first
   // high_cycles slots of its period.
   function automatic logic model_out(input int n, input int div, input int high);
      if (n < 1) return 1'b0;
      return ((n - 1) % div) < high;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge in_clk) begin
      if (model_on) begin
         check("model_def", if_def.outClk, model_out(n_edges, 100, 50));
         check("model_d5", if_d5.outClk, model_out(n_edges, 5, 3));
         check("model_d2", if_d2.outClk, model_out(n_edges, 2, 1));
         check("model_d7", if_d7.outClk, model_out(n_edges, 7, 3));
         check("cnt7_bound", (u_dut7.cnt_q <= 3'd6), 1'b1);
      end
   end

   task automatic check_all_low(input string name);
      check({name, "_def"}, if_def.outClk, 1'b0);
      check({name, "_d5"}, if_d5.outClk, 1'b0);
      check({name, "_d2"}, if_d2.outClk, 1'b0);
      check({name, "_d7"}, if_d7.outClk, 1'b0);
   endtask

   logic pat5 [5];
   logic pat7 [7];

   initial begin
      int r_ofs;
      int hold;
      pat5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      pat7 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      checks   = 0;
      errors   = 0;
      model_on = 1'b0;
      reset    = 1'b0;
      #1 reset = 1'b1;
      model_on = 1'b1;
      #1 check_all_low("in_reset");
      #98 reset = 1'b0;                           // release at 100 ns

      // First edge after release (105 ns) is the first rise.
      #6;
      check("first_rise_def", if_def.outClk, 1'b1);
      for (int k = 0; k < 20; k++) begin
         check("pat_d5", if_d5.outClk, pat5[k % 5]);
         check("pat_d2", if_d2.outClk, (k % 2) == 0);
         check("pat_d7", if_d7.outClk, pat7[k % 7]);
         #10;
      end
      // Now at 306 ns: default fall at 605, second rise at 1105.
      #298 check("def_high_end", if_def.outClk, 1'b1);
      #2   check("def_fall", if_def.outClk, 1'b0);
      #498 check("def_low_end", if_def.outClk, 1'b0);
      #2   check("def_rise2", if_def.outClk, 1'b1);

      // Mid-high reset: 250 ns after release, 23 ns long.
      @(negedge in_clk);
      reset = 1'b1;
      #20;
      @(negedge in_clk);
      reset = 1'b0;
      #250 check("pre_pulse_def", if_def.outClk, 1'b1);
      reset = 1'b1;
      #1 check_all_low("async_drop");
      #22 reset = 1'b0;
      #3   check("restart_rise_def", if_def.outClk, 1'b1);
      #498 check("restart_high_end", if_def.outClk, 1'b1);
      #2   check("restart_fall", if_def.outClk, 0);

      // Random run lengths and reset pulses, asserted and released between edges.
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(20, 400)) @(posedge in_clk);
         @(negedge in_clk);
         r_ofs = $urandom_range(1, 3);
         #(r_ofs) reset = 1'b1;
         #1 check_all_low("rand_drop");
         hold = $urandom_range(0, 5);
         repeat (hold) @(negedge in_clk);
         @(negedge in_clk);
         r_ofs = $urandom_range(1, 3);
         #(r_ofs) reset = 1'b0;
      end
      repeat (250) @(posedge in_clk);
      @(negedge in_clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
